// File: rtl/dht11_pkg.sv
// Shared types and default timing for the DHT11 single-wire controller.
package dht11_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_LOW = 3'd1,
        S_WAIT_RESP = 3'd2,
        S_RESP_LOW  = 3'd3,
        S_RESP_HIGH = 3'd4,
        S_BIT_LOW   = 3'd5,
        S_BIT_HIGH  = 3'd6,
        S_CHECK     = 3'd7
    } state_t;

    localparam int FRAME_BITS = 40;
    localparam int START_US   = 18000;
    localparam int BIT_TH_US  = 40;
    localparam int TOUT_US    = 200;

    // 8-bit wrapping sum of the four data bytes
    function automatic logic [7:0] frame_csum(input logic [31:0] b);
        return b[31:24] + b[23:16] + b[15:8] + b[7:0];
    endfunction

endpackage

// File: rtl/dht11_if.sv
// Host-side bundle of the DHT11 controller: strobe, request, line and result bytes.
interface dht11_if;
    logic       I_ST;
    logic       I_START;
    logic       I_DQ;
    logic       O_DQ_OE;
    logic [7:0] O_HUM_INT;
    logic [7:0] O_HUM_DEC;
    logic [7:0] O_TMP_INT;
    logic [7:0] O_TMP_DEC;
    logic       O_VALID;
    logic       O_ERR;
    logic       O_BUSY;

    modport master (
        output I_ST, I_START, I_DQ,
        input  O_DQ_OE, O_HUM_INT, O_HUM_DEC, O_TMP_INT, O_TMP_DEC, O_VALID, O_ERR, O_BUSY
    );

    modport slave (
        input  I_ST, I_START, I_DQ,
        output O_DQ_OE, O_HUM_INT, O_HUM_DEC, O_TMP_INT, O_TMP_DEC, O_VALID, O_ERR, O_BUSY
    );
endinterface

// File: rtl/dht11_sync.sv
// Two-flop synchronizer for the asynchronous data line plus edge detection.
module dht11_sync (
    input  logic CLK,
    input  logic RST_n,
    input  logic dq,
    output logic level,
    output logic rise,
    output logic fall
);
    logic ff1, ff2, prev;

    // Idle-high reset so a released line never looks like an edge
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ff1  <= 1'b1;
            ff2  <= 1'b1;
            prev <= 1'b1;
        end else begin
            ff1  <= dq;
            ff2  <= ff1;
            prev <= ff2;
        end
    end

    assign level = ff2;
    assign rise  = ff2 & ~prev;
    assign fall  = ~ff2 & prev;
endmodule

// File: rtl/dht11_ctrl.sv
// DHT11 controller: host start pulse, response/bit timing on the 1 us strobe, checksum.
// state       | meaning
// IDLE        | waiting for I_START
// START_LOW   | host holds line low START_US strobes
// WAIT_RESP   | line released, waiting for sensor to pull low
// RESP_LOW    | sensor response low phase
// RESP_HIGH   | sensor response high phase
// BIT_LOW     | low preamble of a data bit
// BIT_HIGH    | high phase; its length encodes the bit
// CHECK       | one cycle: verify checksum, publish or flag error
module dht11_ctrl #(
    parameter int START_US  = dht11_pkg::START_US,
    parameter int BIT_TH_US = dht11_pkg::BIT_TH_US,
    parameter int TOUT_US   = dht11_pkg::TOUT_US
) (
    input logic    CLK,
    input logic    RST_n,
    dht11_if.slave bus
);
    import dht11_pkg::*;

    localparam int CNT_W = $clog2(((START_US > TOUT_US) ? START_US : TOUT_US) + 1);
    localparam logic [CNT_W-1:0] START_TC = CNT_W'(START_US);
    localparam logic [CNT_W-1:0] TOUT_TC  = CNT_W'(TOUT_US);
    localparam logic [CNT_W-1:0] BIT_TH   = CNT_W'(BIT_TH_US);

    state_t                state;
    logic [CNT_W-1:0]      timer;
    logic [5:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  dq_oe, valid, err;
    logic [7:0]            hum_int, hum_dec, tmp_int, tmp_dec;
    logic                  dq_rise, dq_fall, dq_level_unused;
    logic                  phase_edge, sensor_phase;

    // Timing is carried entirely by the edges; the raw level is not needed
    dht11_sync u_sync (
        .CLK   (CLK),
        .RST_n (RST_n),
        .dq    (bus.I_DQ),
        .level (dq_level_unused),
        .rise  (dq_rise),
        .fall  (dq_fall)
    );

    assign sensor_phase = state inside {S_WAIT_RESP, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH};

    always_comb begin
        phase_edge = 1'b0;
        case (state)
            S_WAIT_RESP, S_RESP_HIGH, S_BIT_HIGH: phase_edge = dq_fall;
            S_RESP_LOW, S_BIT_LOW:                phase_edge = dq_rise;
            default:                              phase_edge = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= S_IDLE;
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            dq_oe   <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
            hum_int <= '0;
            hum_dec <= '0;
            tmp_int <= '0;
            tmp_dec <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (bus.I_ST && timer != '1) timer <= timer + 1'b1;

            // Any transition below clears the timer, overriding a same-cycle strobe
            case (state)
                S_IDLE: if (bus.I_START) begin
                    state <= S_START_LOW;
                    dq_oe <= 1'b1;
                    timer <= '0;
                end
                S_START_LOW: if (timer == START_TC) begin
                    state <= S_WAIT_RESP;
                    dq_oe <= 1'b0;
                    timer <= '0;
                end
                S_WAIT_RESP: if (phase_edge) begin
                    state <= S_RESP_LOW;
                    timer <= '0;
                end
                S_RESP_LOW: if (phase_edge) begin
                    state <= S_RESP_HIGH;
                    timer <= '0;
                end
                S_RESP_HIGH: if (phase_edge) begin
                    state   <= S_BIT_LOW;
                    bit_cnt <= '0;
                    timer   <= '0;
                end
                S_BIT_LOW: if (phase_edge) begin
                    state <= S_BIT_HIGH;
                    timer <= '0;
                end
                S_BIT_HIGH: if (phase_edge) begin
                    shreg   <= {shreg[FRAME_BITS-2:0], (timer > BIT_TH)};
                    bit_cnt <= bit_cnt + 6'd1;
                    state   <= (bit_cnt == 6'(FRAME_BITS - 1)) ? S_CHECK : S_BIT_LOW;
                    timer   <= '0;
                end
                S_CHECK: begin
                    if (frame_csum(shreg[39:8]) == shreg[7:0]) begin
                        hum_int <= shreg[39:32];
                        hum_dec <= shreg[31:24];
                        tmp_int <= shreg[23:16];
                        tmp_dec <= shreg[15:8];
                        valid   <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    state <= S_IDLE;
                    timer <= '0;
                end
                default: state <= S_IDLE;
            endcase

            if (sensor_phase && !phase_edge && timer == TOUT_TC) begin
                state <= S_IDLE;
                err   <= 1'b1;
                timer <= '0;
            end
        end
    end

    assign bus.O_DQ_OE   = dq_oe;
    assign bus.O_HUM_INT = hum_int;
    assign bus.O_HUM_DEC = hum_dec;
    assign bus.O_TMP_INT = tmp_int;
    assign bus.O_TMP_DEC = tmp_dec;
    assign bus.O_VALID   = valid;
    assign bus.O_ERR     = err;
    assign bus.O_BUSY    = (state != S_IDLE);
endmodule

// File: tb/tb_dht11_ctrl.sv
// Directed bench for dht11_ctrl with a behavioural DHT11 sensor on the data line.
module tb_dht11_ctrl;
    localparam int T_START = 100;
    localparam int T_TH    = 40;
    localparam int T_TOUT  = 200;

    typedef struct {
        logic [39:0] fr;
        int          hi0;
        int          hi1;
        int          ev;
        int          ee;
        int          hi;
        int          hd;
        int          ti;
        int          td;
    } vec_t;

    logic CLK      = 1'b0;
    logic RST_n    = 1'b0;
    logic sens_lvl = 1'b1;
    logic st_ph    = 1'b0;
    logic abort    = 1'b0;
    logic sens_high = 1'b0;
    int   sens_bit = -1;
    int   st_cnt = 0, n_valid = 0, n_err = 0, n_both = 0;
    int   n_chk = 0, n_fail = 0;
    vec_t vt[5];

    dht11_if bus();

    dht11_ctrl #(.START_US(T_START), .BIT_TH_US(T_TH), .TOUT_US(T_TOUT)) dut (
        .CLK   (CLK),
        .RST_n (RST_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // open-drain line with pull-up: controller pulls low, else the sensor decides
    assign bus.I_DQ = bus.O_DQ_OE ? 1'b0 : sens_lvl;

    // 1 us strobe: one CLK high every two CLKs
    always @(negedge CLK) begin
        st_ph    <= ~st_ph;
        bus.I_ST <= st_ph;
    end

    always @(posedge CLK) if (bus.I_ST) st_cnt <= st_cnt + 1;

    always @(negedge CLK) begin
        if (bus.O_VALID) n_valid <= n_valid + 1;
        if (bus.O_ERR) n_err <= n_err + 1;
        if (bus.O_VALID && bus.O_ERR) n_both <= n_both + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_us(input int n);
        for (int i = 0; i < n && !abort; i++) begin
            @(posedge CLK);
            while (!bus.I_ST && !abort) @(posedge CLK);
        end
        @(negedge CLK);
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        bus.I_START = 1'b1;
        @(negedge CLK);
        bus.I_START = 1'b0;
    endtask

    task automatic sensor_frame(input logic [39:0] fr, input int hi0, input int hi1);
        int k = 0;
        while (!bus.O_DQ_OE && k < 50) begin @(negedge CLK); k++; end
        check("oe_assert_wait", int'(k < 50), 1);
        k = 0;
        while (bus.O_DQ_OE && k < 4 * T_START + 100) begin @(negedge CLK); k++; end
        check("oe_release_wait", int'(k < 4 * T_START + 100), 1);
        wait_us(20);
        sens_lvl = 1'b0;
        wait_us(80);
        sens_lvl = 1'b1;
        wait_us(80);
        for (int i = 0; i < 40; i++) begin
            sens_bit  = i;
            sens_lvl  = 1'b0;
            wait_us(50);
            sens_lvl  = 1'b1;
            sens_high = 1'b1;
            wait_us(fr[39-i] ? hi1 : hi0);
            sens_high = 1'b0;
        end
        sens_lvl = 1'b0;
        wait_us(50);
        sens_lvl = 1'b1;
        sens_bit = -1;
    endtask

    task automatic check_bytes(input string tag, input int hi, input int hd, input int ti, input int td);
        check({tag, "_hum_int"}, int'(bus.O_HUM_INT), hi);
        check({tag, "_hum_dec"}, int'(bus.O_HUM_DEC), hd);
        check({tag, "_tmp_int"}, int'(bus.O_TMP_INT), ti);
        check({tag, "_tmp_dec"}, int'(bus.O_TMP_DEC), td);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, b, c, k, v0, e0;
        vt[0] = '{40'h37_00_19_00_50, 27, 70, 1, 0, 'h37, 'h00, 'h19, 'h00};
        vt[1] = '{40'h37_00_19_00_51, 27, 70, 0, 1, 'h37, 'h00, 'h19, 'h00};
        vt[2] = '{40'hFF_00_00_00_FF, 40, 42, 1, 0, 'hFF, 'h00, 'h00, 'h00};
        vt[3] = '{40'h41_05_17_03_60, 27, 70, 1, 0, 'h41, 'h05, 'h17, 'h03};
        vt[4] = '{40'hFF_FF_01_02_01, 27, 70, 1, 0, 'hFF, 'hFF, 'h01, 'h02};

        bus.I_START = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_oe", int'(bus.O_DQ_OE), 0);
        check("rst_valid", int'(bus.O_VALID), 0);
        check("rst_err", int'(bus.O_ERR), 0);
        check("rst_busy", int'(bus.O_BUSY), 0);
        check_bytes("rst", 0, 0, 0, 0);
        RST_n = 1'b1;
        repeat (3) @(negedge CLK);
        check("idle_busy", int'(bus.O_BUSY), 0);

        for (int i = 0; i < 5; i++) begin
            v0 = n_valid;
            e0 = n_err;
            pulse_start();
            sensor_frame(vt[i].fr, vt[i].hi0, vt[i].hi1);
            repeat (4) @(negedge CLK);
            check($sformatf("row%0d_valid", i), n_valid - v0, vt[i].ev);
            check($sformatf("row%0d_err", i), n_err - e0, vt[i].ee);
            check($sformatf("row%0d_busy", i), int'(bus.O_BUSY), 0);
            check_bytes($sformatf("row%0d", i), vt[i].hi, vt[i].hd, vt[i].ti, vt[i].td);
        end

        // no sensor: start pulse length and response timeout measured in strobes
        e0 = n_err;
        pulse_start();
        k = 0;
        while (!bus.O_DQ_OE && k < 10) begin @(negedge CLK); k++; end
        a = st_cnt;
        check("nosens_busy", int'(bus.O_BUSY), 1);
        k = 0;
        while (bus.O_DQ_OE && k < 4 * T_START) begin @(negedge CLK); k++; end
        b = st_cnt;
        check("nosens_start_len", b - a, T_START);
        k = 0;
        while (!bus.O_ERR && k < 4 * T_TOUT) begin @(negedge CLK); k++; end
        c = st_cnt;
        check("nosens_tout_len", c - b, T_TOUT);
        check("nosens_busy_at_err", int'(bus.O_BUSY), 0);
        @(negedge CLK);
        check("nosens_err_1cyc", int'(bus.O_ERR), 0);
        check("nosens_err_cnt", n_err - e0, 1);
        check_bytes("nosens", 'hFF, 'hFF, 'h01, 'h02);

        // reset in the middle of bit 17
        pulse_start();
        fork
            sensor_frame(vt[0].fr, vt[0].hi0, vt[0].hi1);
            begin
                k = 0;
                while (sens_bit != 17 && k < 20000) begin @(negedge CLK); k++; end
                repeat (60) @(negedge CLK);
                RST_n = 1'b0;
                #1;
                check("midrst_oe", int'(bus.O_DQ_OE), 0);
                check("midrst_busy", int'(bus.O_BUSY), 0);
                check("midrst_valid_err", int'({bus.O_VALID, bus.O_ERR}), 0);
                check_bytes("midrst", 0, 0, 0, 0);
                abort = 1'b1;
            end
        join
        abort = 1'b0;
        sens_lvl = 1'b1;
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;
        repeat (3) @(negedge CLK);
        v0 = n_valid;
        pulse_start();
        sensor_frame(vt[0].fr, vt[0].hi0, vt[0].hi1);
        repeat (4) @(negedge CLK);
        check("after_rst_valid", n_valid - v0, 1);
        check_bytes("after_rst", 'h37, 'h00, 'h19, 'h00);

        // start requests while busy must not restart the transaction
        v0 = n_valid;
        e0 = n_err;
        pulse_start();
        fork
            sensor_frame(vt[3].fr, vt[3].hi0, vt[3].hi1);
            begin
                repeat (30) @(negedge CLK);
                pulse_start();
                check("ign_oe_held", int'(bus.O_DQ_OE), 1);
                k = 0;
                while (!(sens_bit == 10 && sens_high) && k < 20000) begin @(negedge CLK); k++; end
                repeat (10) @(negedge CLK);
                pulse_start();
            end
        join
        repeat (4) @(negedge CLK);
        check("ign_valid", n_valid - v0, 1);
        check("ign_err", n_err - e0, 0);
        check_bytes("ign", 'h41, 'h05, 'h17, 'h03);
        check("valid_err_overlap", n_both, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
